// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg: shared stall encodings, boundary indices and FSM states
package pipeline_controller_pkg;
  localparam int STALL_BUS = 5;
  localparam int ADDR_BUS = 32;
  localparam int STALL_PC = 0;
  localparam int STALL_IFID = 1;
  localparam int STALL_IDEX = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_MEMWB = 4;
  typedef logic [STALL_BUS-1:0] stall_t;
  localparam stall_t STALL_NONE = 5'b00000;
  localparam stall_t STALL_IF = 5'b00001;
  localparam stall_t STALL_ID = 5'b00011;
  localparam stall_t STALL_EX = 5'b00111;
  localparam stall_t STALL_MEM = 5'b01111;
  typedef enum logic [1:0] {RUN, WAIT, FLUSH} state_t;
endpackage

// File: rtl/pipeline_controller_if.sv
// pipeline_controller_if: stall requests, exception input and stall/flush/perf outputs
interface pipeline_controller_if
  import pipeline_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BUS,
  parameter int CNT_WIDTH = 32
);
  logic stall_req_if;
  logic stall_req_id;
  logic stall_req_ex;
  logic stall_req_mem;
  logic exc_valid;
  logic [ADDR_WIDTH-1:0] exc_pc;
  stall_t stall;
  logic flush;
  logic [ADDR_WIDTH-1:0] flush_pc;
  logic [CNT_WIDTH-1:0] perf_stall_cycles;
  logic [CNT_WIDTH-1:0] perf_flush_count;
  modport master (
    input stall_req_if, stall_req_id, stall_req_ex, stall_req_mem, exc_valid, exc_pc,
    output stall, flush, flush_pc, perf_stall_cycles, perf_flush_count
  );
  modport slave (
    output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem, exc_valid, exc_pc,
    input stall, flush, flush_pc, perf_stall_cycles, perf_flush_count
  );
endinterface

// File: rtl/stall_encoder.sv
// stall_encoder: highest requesting stage wins, giving a contiguous stall vector
module stall_encoder
  import pipeline_controller_pkg::*;
(
  input  logic   req_if,
  input  logic   req_id,
  input  logic   req_ex,
  input  logic   req_mem,
  output stall_t stall
);
  always_comb begin
    stall = req_mem ? STALL_MEM : req_ex ? STALL_EX : req_id ? STALL_ID : req_if ? STALL_IF : STALL_NONE;
  end
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall vector merge, deferred exception flush sequencing and perf counters
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BUS,
  parameter int CNT_WIDTH = 32
)
(
  input logic clk,
  input logic rst,
  pipeline_controller_if.master bus
);
  state_t state, next;
  stall_t enc;
  logic [ADDR_WIDTH-1:0] tgt;
  stall_encoder u_enc (
    .req_if (bus.stall_req_if),
    .req_id (bus.stall_req_id),
    .req_ex (bus.stall_req_ex),
    .req_mem(bus.stall_req_mem),
    .stall  (enc)
  );
  always_comb begin
    next = state == FLUSH ? RUN : (state == WAIT || bus.exc_valid) ? (bus.stall_req_mem ? WAIT : FLUSH) : RUN;
    bus.flush = !rst && state == FLUSH;
    bus.stall = (rst || state == FLUSH) ? STALL_NONE : enc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      tgt <= '0;
      bus.flush_pc <= '0;
      bus.perf_stall_cycles <= '0;
      bus.perf_flush_count <= '0;
    end else begin
      state <= next;
      if (state == RUN && bus.exc_valid) tgt <= bus.exc_pc;
      if (next == FLUSH) bus.flush_pc <= state == RUN ? bus.exc_pc : tgt;
      bus.perf_stall_cycles <= bus.perf_stall_cycles + CNT_WIDTH'(|bus.stall);
      bus.perf_flush_count <= bus.perf_flush_count + CNT_WIDTH'(bus.flush);
    end
  end
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed checks of stall priority, flush sequencing, reset and counter wrap
module tb_pipeline_controller;
  import pipeline_controller_pkg::*;
  logic clk;
  logic rst;
  int checks;
  int errors;
  pipeline_controller_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) b ();
  pipeline_controller_if #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) s ();
  assign s.stall_req_if = b.stall_req_if;
  assign s.stall_req_id = b.stall_req_id;
  assign s.stall_req_ex = b.stall_req_ex;
  assign s.stall_req_mem = b.stall_req_mem;
  assign s.exc_valid = b.exc_valid;
  assign s.exc_pc = b.exc_pc;
  pipeline_controller #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(b));
  pipeline_controller #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) dut_small (.clk(clk), .rst(rst), .bus(s));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic reqs(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
    b.stall_req_if = r_if;
    b.stall_req_id = r_id;
    b.stall_req_ex = r_ex;
    b.stall_req_mem = r_mem;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    reqs(1, 1, 1, 1);
    b.exc_valid = 1'b0;
    b.exc_pc = '0;
    tick();
    tick();
    check("rst_stall", b.stall, 5'b00000);
    check("rst_flush", b.flush, 0);
    check("rst_flush_pc", b.flush_pc, 0);
    check("rst_perf_stall", b.perf_stall_cycles, 0);
    check("rst_perf_flush", b.perf_flush_count, 0);
    rst = 1'b0;
    reqs(0, 0, 0, 0);
    tick();
    check("idle_stall", b.stall, 5'b00000);
    reqs(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check("prio_if_ex", b.stall, 5'b00111);
      tick();
    end
    check("perf_stall_3", b.perf_stall_cycles, 3);
    reqs(0, 1, 0, 0);
    #1 check("prio_id", b.stall, 5'b00011);
    tick();
    reqs(0, 0, 1, 0);
    b.exc_valid = 1'b1;
    b.exc_pc = 32'hBFC00380;
    #1 check("pre_flush_stall", b.stall, 5'b00111);
    check("pre_flush_flush", b.flush, 0);
    tick();
    b.exc_valid = 1'b0;
    #1 check("imm_flush", b.flush, 1);
    check("imm_flush_pc", b.flush_pc, 32'hBFC00380);
    check("imm_flush_stall", b.stall, 5'b00000);
    tick();
    check("imm_post_flush", b.flush, 0);
    check("imm_flush_count", b.perf_flush_count, 1);
    check("imm_stall_count", b.perf_stall_cycles, 5);
    check("imm_post_stall", b.stall, 5'b00111);
    reqs(0, 0, 0, 1);
    b.exc_valid = 1'b1;
    b.exc_pc = 32'h12345670;
    #1 check("def_enter_stall", b.stall, 5'b01111);
    check("def_enter_flush", b.flush, 0);
    tick();
    b.exc_pc = 32'h80000000;
    for (int i = 0; i < 3; i++) begin
      #1 check("def_wait_flush", b.flush, 0);
      check("def_wait_stall", b.stall, 5'b01111);
      tick();
    end
    reqs(0, 0, 0, 0);
    b.exc_valid = 1'b0;
    #1 check("def_release_flush", b.flush, 0);
    check("def_release_stall", b.stall, 5'b00000);
    tick();
    #1 check("def_flush", b.flush, 1);
    check("def_flush_pc", b.flush_pc, 32'h12345670);
    tick();
    check("def_post_flush", b.flush, 0);
    check("def_flush_count", b.perf_flush_count, 2);
    check("def_stall_count", b.perf_stall_cycles, 9);
    check("def_flush_pc_hold", b.flush_pc, 32'h12345670);
    reqs(0, 0, 0, 1);
    b.exc_valid = 1'b1;
    b.exc_pc = 32'hDEAD0000;
    tick();
    rst = 1'b1;
    b.exc_valid = 1'b0;
    tick();
    rst = 1'b0;
    reqs(0, 0, 0, 0);
    check("wrst_flush_pc", b.flush_pc, 0);
    check("wrst_perf_stall", b.perf_stall_cycles, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check("wrst_no_flush", b.flush, 0);
      tick();
    end
    check("wrst_flush_count", b.perf_flush_count, 0);
    reqs(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) tick();
    check("wrap_small", s.perf_stall_cycles, 1);
    check("wrap_wide", b.perf_stall_cycles, 17);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
